reg_file_mp: RTL and testbench

Parametrised multi-port register file for the core. Provides N combinational read ports and M write ports; the processor, APU and future units each get their own write port. Same-register write conflicts are resolved by a round-robin arbiter. A per-register busy scoreboard lets the issue stage reserve a destination register until the producing unit writes it back.

---
 rtl/reg_file_mp_pkg.sv | 24 ++
 rtl/reg_file_mp_if.sv | 32 +++
 rtl/reg_file_mp_wr_arb.sv | 51 +++++
 rtl/reg_file_mp.sv | 121 ++++++++++++
 tb/tb_reg_file_mp.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared types and helpers for the multi-port register file.
// Default-sized types serve testbenches; parametrised logic derives its own widths.
package reg_file_pkg;

    localparam int NUM_REGS_DEF   = 32;
    localparam int DATA_WIDTH_DEF = 32;

    // Index width with a floor of one bit, so single-entry sets still get a signal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Position of idx in a round-robin scan starting at ptr over n entries.
    function automatic int rr_dist(input int idx, input int ptr, input int n);
        return (idx + n - (ptr % n)) % n;
    endfunction

    localparam int SEL_W    = idx_width(NUM_REGS_DEF);
    localparam int ZERO_IDX = 0;

    typedef logic [SEL_W-1:0]          reg_sel_t;
    typedef logic [DATA_WIDTH_DEF-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus bundle between the core (master) and the register file (slave).
interface reg_file_mp_if
    import reg_file_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_WR_PORTS = 2
) ();
    localparam int RSW = idx_width(NUM_REGS);

    logic [NUM_RD_PORTS*RSW-1:0]        rd_sel;
    logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data;
    logic [NUM_WR_PORTS-1:0]            wr_req;
    logic [NUM_WR_PORTS*RSW-1:0]        wr_sel;
    logic [NUM_WR_PORTS*DATA_WIDTH-1:0] wr_data;
    logic [NUM_WR_PORTS-1:0]            wr_gnt;
    logic                               rsv_req;
    logic [RSW-1:0]                     rsv_sel;
    logic [NUM_REGS-1:0]                busy;

    modport master (
        output rd_sel, wr_req, wr_sel, wr_data, rsv_req, rsv_sel,
        input  rd_data, wr_gnt, busy
    );

    modport slave (
        input  rd_sel, wr_req, wr_sel, wr_data, rsv_req, rsv_sel,
        output rd_data, wr_gnt, busy
    );

endinterface

// File: rtl/reg_file_mp_wr_arb.sv
// Combinational write-port arbiter: one winner per contested register,
// chosen by a round-robin scan from the current pointer.
module reg_file_wr_arb
    import reg_file_pkg::*;
#(
    parameter int NUM_WR_PORTS = 2,
    parameter int SW           = 5,
    parameter int PTR_W        = 1
) (
    input  logic [NUM_WR_PORTS-1:0]    i_wr_req,
    input  logic [NUM_WR_PORTS*SW-1:0] i_wr_sel,
    input  logic [PTR_W-1:0]           i_rr_ptr,
    output logic [NUM_WR_PORTS-1:0]    o_wr_gnt,
    output logic                       o_conflict,
    output logic [PTR_W-1:0]           o_rr_ptr_next
);

    logic [SW-1:0]           w_sel [NUM_WR_PORTS];
    logic [NUM_WR_PORTS-1:0] w_clash;

    generate
        for (genvar gi = 0; gi < NUM_WR_PORTS; gi++) begin : g_unpack
            assign w_sel[gi] = i_wr_sel[gi*SW +: SW];
        end
    endgenerate

    always_comb begin
        o_wr_gnt      = '0;
        w_clash       = '0;
        o_rr_ptr_next = i_rr_ptr;
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
            o_wr_gnt[p] = i_wr_req[p];
            for (int q = 0; q < NUM_WR_PORTS; q++) begin
                if (q != p && i_wr_req[p] && i_wr_req[q] && w_sel[q] == w_sel[p]) begin
                    w_clash[p] = 1'b1;
                    // A rival reached earlier in the scan takes this register.
                    if (rr_dist(q, int'(i_rr_ptr), NUM_WR_PORTS) <
                        rr_dist(p, int'(i_rr_ptr), NUM_WR_PORTS))
                        o_wr_gnt[p] = 1'b0;
                end
            end
        end
        o_conflict = |w_clash;
        // Descending scan leaves the lowest-index conflicting winner in place.
        for (int p = NUM_WR_PORTS - 1; p >= 0; p--) begin
            if (o_wr_gnt[p] && w_clash[p])
                o_rr_ptr_next = PTR_W'((p + 1) % NUM_WR_PORTS);
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with round-robin write arbitration, optional
// read bypass, hard-wired zero register and a per-register busy scoreboard.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_WR_PORTS = 2,
    parameter int ZERO_REG     = 1,
    parameter int BYPASS       = 0
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_mp_if.slave  bus
);

    localparam int RSW   = idx_width(NUM_REGS);
    localparam int PTR_W = idx_width(NUM_WR_PORTS);

    logic [DATA_WIDTH-1:0]          r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]            r_busy;
    logic [PTR_W-1:0]               r_rr_ptr;

    logic [RSW-1:0]                 w_wr_sel  [NUM_WR_PORTS];
    logic [DATA_WIDTH-1:0]          w_wr_data [NUM_WR_PORTS];
    logic [NUM_WR_PORTS-1:0]        w_arb_gnt;
    logic [NUM_WR_PORTS-1:0]        w_wr_fire;
    logic                           w_conflict;
    logic [PTR_W-1:0]               w_rr_ptr_next;
    logic [NUM_REGS-1:0]            w_we;
    logic [DATA_WIDTH-1:0]          w_wd [NUM_REGS];
    logic [NUM_REGS-1:0]            w_busy_next;
    logic [NUM_RD_PORTS*DATA_WIDTH-1:0] w_rd_data;

    generate
        for (genvar gi = 0; gi < NUM_WR_PORTS; gi++) begin : g_wr_unpack
            assign w_wr_sel[gi]  = bus.wr_sel[gi*RSW +: RSW];
            assign w_wr_data[gi] = bus.wr_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    reg_file_wr_arb #(
        .NUM_WR_PORTS (NUM_WR_PORTS),
        .SW           (RSW),
        .PTR_W        (PTR_W)
    ) u_wr_arb (
        .i_wr_req      (bus.wr_req),
        .i_wr_sel      (bus.wr_sel),
        .i_rr_ptr      (r_rr_ptr),
        .o_wr_gnt      (w_arb_gnt),
        .o_conflict    (w_conflict),
        .o_rr_ptr_next (w_rr_ptr_next)
    );

    // Nothing is granted while reset is held, so no stray write or bypass.
    assign w_wr_fire   = bus.wr_req & w_arb_gnt & {NUM_WR_PORTS{~rst}};
    assign bus.wr_gnt  = w_arb_gnt & {NUM_WR_PORTS{~rst}};
    assign bus.busy    = r_busy;
    assign bus.rd_data = w_rd_data;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            w_we[r] = 1'b0;
            w_wd[r] = '0;
            for (int p = 0; p < NUM_WR_PORTS; p++) begin
                if (w_wr_fire[p] && w_wr_sel[p] == RSW'(r)) begin
                    w_we[r] = 1'b1;
                    w_wd[r] = w_wr_data[p];
                end
            end
            if (ZERO_REG != 0 && r == ZERO_IDX)
                w_we[r] = 1'b0;
        end
    end

    // A same-cycle reservation overrides the write-back clear.
    always_comb begin
        w_busy_next = r_busy & ~w_we;
        if (bus.rsv_req && !(ZERO_REG != 0 && bus.rsv_sel == RSW'(ZERO_IDX)))
            w_busy_next[bus.rsv_sel] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++)
                r_regs[r] <= '0;
            r_busy   <= '0;
            r_rr_ptr <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_we[r])
                    r_regs[r] <= w_wd[r];
            end
            r_busy <= w_busy_next;
            if (w_conflict)
                r_rr_ptr <= w_rr_ptr_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd
            logic [RSW-1:0]        w_rs;
            logic [DATA_WIDTH-1:0] w_rd;
            assign w_rs = bus.rd_sel[gi*RSW +: RSW];
            always_comb begin
                w_rd = r_regs[w_rs];
                if (BYPASS != 0) begin
                    for (int p = 0; p < NUM_WR_PORTS; p++) begin
                        if (w_wr_fire[p] && w_wr_sel[p] == w_rs)
                            w_rd = w_wr_data[p];
                    end
                end
                if (ZERO_REG != 0 && w_rs == RSW'(ZERO_IDX))
                    w_rd = '0;
            end
            assign w_rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = w_rd;
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a non-bypass and a bypass instance share one stimulus
// stream; granted writes are queued as expected reads and checked a cycle later.
module tb_reg_file_mp;
    import reg_file_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_file_mp_if #(.NUM_REGS(32), .DATA_WIDTH(32), .NUM_RD_PORTS(2), .NUM_WR_PORTS(2)) ifa ();
    reg_file_mp_if #(.NUM_REGS(32), .DATA_WIDTH(32), .NUM_RD_PORTS(2), .NUM_WR_PORTS(2)) ifb ();

    reg_file_mp #(.ZERO_REG(1), .BYPASS(0)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
    reg_file_mp #(.ZERO_REG(1), .BYPASS(1)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

    assign ifb.rd_sel  = ifa.rd_sel;
    assign ifb.wr_req  = ifa.wr_req;
    assign ifb.wr_sel  = ifa.wr_sel;
    assign ifb.wr_data = ifa.wr_data;
    assign ifb.rsv_req = ifa.rsv_req;
    assign ifb.rsv_sel = ifa.rsv_sel;

    typedef struct {
        logic [1:0]  req;
        reg_sel_t    s0, s1;
        reg_data_t   d0, d1;
        logic        rsv;
        reg_sel_t    rsel;
        logic [1:0]  egnt;
        int          bidx;
        logic        ebusy;
    } vec_t;

    typedef struct {
        reg_sel_t  sel;
        reg_data_t data;
    } sb_t;

    vec_t vt [11];
    sb_t  sbq [$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] req, input reg_sel_t s0, input reg_sel_t s1,
                         input reg_data_t d0, input reg_data_t d1,
                         input logic rsv, input reg_sel_t rsel);
        ifa.wr_req  = req;
        ifa.wr_sel  = {s1, s0};
        ifa.wr_data = {d1, d0};
        ifa.rsv_req = rsv;
        ifa.rsv_sel = rsel;
    endtask

    task automatic idle();
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0);
    endtask

    task automatic set_rd(input reg_sel_t a, input reg_sel_t b);
        ifa.rd_sel = {b, a};
    endtask

    // Queue the architectural effect of a write the bench expects to be granted.
    task automatic push_wr(input reg_sel_t s, input reg_data_t d);
        sb_t e;
        e.sel  = s;
        e.data = (s == 5'd0) ? 32'h0 : d;
        sbq.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            set_rd(e.sel, e.sel);
            #1;
            chk($sformatf("rd0_r%0d", e.sel), ifa.rd_data[31:0], e.data);
            chk($sformatf("rd1_r%0d", e.sel), ifa.rd_data[63:32], e.data);
            chk($sformatf("rdB_r%0d", e.sel), ifb.rd_data[31:0], e.data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //           req    s0     s1     d0            d1            rsv   rsel   egnt   bidx ebusy
        vt[0]  = '{2'b11, 5'd5, 5'd7, 32'hDEADBEEF, 32'h12345678, 1'b0, 5'd0, 2'b11, 9, 1'b0};
        vt[1]  = '{2'b11, 5'd3, 5'd3, 32'h0000000A, 32'h0000000B, 1'b0, 5'd0, 2'b01, 9, 1'b0};
        vt[2]  = '{2'b11, 5'd3, 5'd3, 32'h0000000A, 32'h0000000B, 1'b0, 5'd0, 2'b10, 9, 1'b0};
        vt[3]  = '{2'b11, 5'd3, 5'd3, 32'h0000000A, 32'h0000000B, 1'b0, 5'd0, 2'b01, 9, 1'b0};
        vt[4]  = '{2'b11, 5'd3, 5'd3, 32'h0000000A, 32'h0000000B, 1'b0, 5'd0, 2'b10, 9, 1'b0};
        vt[5]  = '{2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0,        1'b0, 5'd0, 2'b01, 0, 1'b0};
        vt[6]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b1, 5'd9, 2'b00, 9, 1'b1};
        vt[7]  = '{2'b10, 5'd0, 5'd9, 32'h0,        32'h00000055, 1'b0, 5'd0, 2'b10, 9, 1'b0};
        vt[8]  = '{2'b10, 5'd0, 5'd9, 32'h0,        32'h00000066, 1'b1, 5'd9, 2'b10, 9, 1'b1};
        vt[9]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b1, 5'd9, 2'b00, 9, 1'b1};
        vt[10] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b1, 5'd0, 2'b00, 0, 1'b0};

        // Reset held with live requests: everything reads zero, nothing granted.
        drive(2'b11, 5'd5, 5'd6, 32'h1, 32'h2, 1'b1, 5'd4);
        set_rd(5'd0, 5'd0);
        #1;
        chk("rst_gnt", 32'(ifa.wr_gnt), 32'h0);
        for (int r = 0; r < 32; r++) begin
            set_rd(5'(r), 5'(31 - r));
            #1;
            chk($sformatf("rst_rd0_r%0d", r), ifa.rd_data[31:0], 32'h0);
            chk($sformatf("rst_rd1_r%0d", 31 - r), ifa.rd_data[63:32], 32'h0);
        end
        chk("rst_busy", ifa.busy, 32'h0);
        idle();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_busy", ifa.busy, 32'h0);

        for (int v = 0; v < 11; v++) begin
            drive(vt[v].req, vt[v].s0, vt[v].s1, vt[v].d0, vt[v].d1, vt[v].rsv, vt[v].rsel);
            #1;
            chk($sformatf("gnt_v%0d", v), 32'(ifa.wr_gnt), 32'(vt[v].egnt));
            if (vt[v].egnt[0]) push_wr(vt[v].s0, vt[v].d0);
            if (vt[v].egnt[1]) push_wr(vt[v].s1, vt[v].d1);
            @(posedge clk); #1;
            idle();
            drain();
            chk($sformatf("busy%0d_v%0d", vt[v].bidx, v), 32'(ifa.busy[vt[v].bidx]), 32'(vt[v].ebusy));
            $display("vec %0d: req=%b gnt=%b busy=%h", v, vt[v].req, vt[v].egnt, ifa.busy);
        end

        // Same-cycle bypass of a granted write on the bypass instance only.
        drive(2'b01, 5'd4, 5'd0, 32'h00000077, 32'h0, 1'b0, 5'd0);
        set_rd(5'd4, 5'd4);
        #1;
        chk("byp_gnt", 32'(ifa.wr_gnt), 32'h1);
        chk("byp_B_rd0", ifb.rd_data[31:0], 32'h00000077);
        chk("byp_B_rd1", ifb.rd_data[63:32], 32'h00000077);
        chk("nobyp_A_rd0", ifa.rd_data[31:0], 32'h0);
        @(posedge clk); #1;
        idle();
        #1;
        chk("byp_A_after", ifa.rd_data[31:0], 32'h00000077);
        $display("bypass: wrote r4=0x77 A=%h B=%h", ifa.rd_data[31:0], ifb.rd_data[31:0]);

        // Asynchronous reset mid-transfer clears state before any clock edge.
        drive(2'b11, 5'd5, 5'd7, 32'h1, 32'h2, 1'b1, 5'd12);
        set_rd(5'd5, 5'd7);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_rd0", ifa.rd_data[31:0], 32'h0);
        chk("mid_rst_rd1", ifa.rd_data[63:32], 32'h0);
        chk("mid_rst_busy", ifa.busy, 32'h0);
        chk("mid_rst_gnt", 32'(ifa.wr_gnt), 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        idle();
        #1;
        chk("post_mid_rst_r5", ifa.rd_data[31:0], 32'h0);
        chk("post_mid_rst_busy", ifa.busy, 32'h0);
        $display("reset: mid-transfer reset applied and released");

        // Requester re-issues after reset.
        drive(2'b01, 5'd5, 5'd0, 32'h00000099, 32'h0, 1'b0, 5'd0);
        #1;
        chk("reissue_gnt", 32'(ifa.wr_gnt), 32'h1);
        push_wr(5'd5, 32'h00000099);
        @(posedge clk); #1;
        idle();
        drain();
        $display("reissue: r5=%h", ifa.rd_data[31:0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
